// File: rtl/piano_pkg.sv
// Shared types and constants for the keyboard-piano note sequencer.
package piano_pkg;

  localparam int KEY_W    = 8;
  localparam int PERIOD_W = 24;
  localparam int LEN_W    = 5;
  localparam int CYC_W    = 32;

  // Production defaults: 125 MHz clock, 100 ms per step, 1 ms gap.
  localparam int unsigned DEF_DUR_STEP_CYCLES   = 12500000;
  localparam int unsigned DEF_DUR_DEFAULT_STEPS = 5;
  localparam int unsigned DEF_DUR_MIN_STEPS     = 1;
  localparam int unsigned DEF_DUR_MAX_STEPS     = 20;
  localparam int unsigned DEF_GAP_CYCLES        = 125000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    ECHO   = 3'd3,
    LOOKUP = 3'd4,
    PLAY   = 3'd5,
    GAP    = 3'd6
  } piano_state_e;

endpackage

// File: rtl/piano_note_timer.sv
// Loadable step/cycle down-counter. A load of (steps, step_cycles) runs for
// exactly steps*step_cycles cycles without ever forming the product; the
// final counted cycle raises done_pulse. step_cycles must be at least 1.
module piano_note_timer
  import piano_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] steps,
  input  logic [CYC_W-1:0] step_cycles,
  output logic             running,
  output logic             done_pulse
);

  logic [LEN_W-1:0] step_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_reload;
  logic             step_end;

  assign step_end   = (cyc_cnt <= CYC_W'(1));
  assign running    = (step_cnt != '0);
  assign done_pulse = running && step_end && (step_cnt == LEN_W'(1));

  // Count cycles within a step, then steps; stop at zero (no wrap).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      step_cnt   <= '0;
      cyc_cnt    <= '0;
      cyc_reload <= '0;
    end else if (load) begin
      step_cnt   <= steps;
      cyc_cnt    <= step_cycles;
      cyc_reload <= step_cycles;
    end else if (running) begin
      if (step_end) begin
        step_cnt <= step_cnt - LEN_W'(1);
        cyc_cnt  <= cyc_reload;
      end else begin
        cyc_cnt <= cyc_cnt - CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/piano_note_sequencer.sv
// Keyboard-piano sequencer: pops a key from the UART RX FIFO, echoes it to
// the TX FIFO, looks it up in the scale ROM and plays it for the rotary-set
// note length followed by a silent gap.
// Optional feature macro PIANO_RETRIGGER_EN: a new key arriving during PLAY
// or GAP cuts the current note and is read immediately.
// state_dbg exposes the FSM state for checkers.
// Handshake: rd_en pops one byte whose data is valid the following cycle;
// wr_en pushes din in the same cycle and is only asserted while not full.
module piano_note_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned DUR_STEP_CYCLES   = DEF_DUR_STEP_CYCLES,
  parameter int unsigned DUR_DEFAULT_STEPS = DEF_DUR_DEFAULT_STEPS,
  parameter int unsigned DUR_MIN_STEPS     = DEF_DUR_MIN_STEPS,
  parameter int unsigned DUR_MAX_STEPS     = DEF_DUR_MAX_STEPS,
  parameter int unsigned GAP_CYCLES        = DEF_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rotary_event,
  input  logic                rotary_left,
  input  logic [KEY_W-1:0]    ua_receive_dout,
  input  logic                ua_receive_empty,
  output logic                ua_receive_rd_en,
  output logic [KEY_W-1:0]    ua_transmit_din,
  input  logic                ua_transmit_full,
  output logic                ua_transmit_wr_en,
  output logic [KEY_W-1:0]    rom_address,
  input  logic [PERIOD_W-1:0] rom_data,
  output logic [PERIOD_W-1:0] tone_period,
  output logic                tone_enable,
  output logic [LEN_W-1:0]    note_len_steps,
  output logic                busy,
  output piano_state_e        state_dbg
);

  localparam logic [LEN_W-1:0] LEN_DEF  = LEN_W'(DUR_DEFAULT_STEPS);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(DUR_MIN_STEPS);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DUR_MAX_STEPS);
  localparam logic [CYC_W-1:0] STEP_CYC = CYC_W'(DUR_STEP_CYCLES);
  localparam logic [CYC_W-1:0] GAP_CYC  = CYC_W'(GAP_CYCLES);

  piano_state_e     state, state_nxt;
  logic [KEY_W-1:0] key_r;
  logic             cap_key, cap_period;
  logic             t_load, t_clear, t_running, t_done;
  logic [LEN_W-1:0] t_steps;
  logic [CYC_W-1:0] t_cycles;

  // The timer's step counter holds the length captured at LOOKUP, so later
  // rotary updates never change a note already in progress.
  piano_note_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (t_clear),
    .load        (t_load),
    .steps       (t_steps),
    .step_cycles (t_cycles),
    .running     (t_running),
    .done_pulse  (t_done)
  );

  assign ua_transmit_din = key_r;
  assign rom_address     = key_r;
  assign tone_enable     = (state == PLAY) && t_running;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt         = state;
    ua_receive_rd_en  = 1'b0;
    ua_transmit_wr_en = 1'b0;
    cap_key           = 1'b0;
    cap_period        = 1'b0;
    t_load            = 1'b0;
    t_clear           = 1'b0;
    t_steps           = note_len_steps;
    t_cycles          = STEP_CYC;
    case (state)
      IDLE: if (!ua_receive_empty) state_nxt = READ;
      READ: begin
        ua_receive_rd_en = 1'b1;
        state_nxt        = LATCH;
      end
      LATCH: begin
        cap_key   = 1'b1;
        state_nxt = ECHO;
      end
      ECHO: begin
        if (!ua_transmit_full) begin
          ua_transmit_wr_en = 1'b1;
          state_nxt         = LOOKUP;
        end
      end
      LOOKUP: begin
        cap_period = 1'b1;
        if (rom_data == '0) begin
          state_nxt = IDLE;
        end else begin
          t_load    = 1'b1;
          state_nxt = PLAY;
        end
      end
      PLAY: begin
`ifdef PIANO_RETRIGGER_EN
        if (!ua_receive_empty) begin
          t_clear   = 1'b1;
          state_nxt = READ;
        end else
`endif
        if (t_done) begin
          t_load    = 1'b1;
          t_steps   = LEN_W'(1);
          t_cycles  = GAP_CYC;
          state_nxt = GAP;
        end
      end
      GAP: begin
`ifdef PIANO_RETRIGGER_EN
        if (!ua_receive_empty) begin
          t_clear   = 1'b1;
          state_nxt = READ;
        end else
`endif
        if (t_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key byte and tone period capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r       <= '0;
      tone_period <= '0;
    end else begin
      if (cap_key)    key_r       <= ua_receive_dout;
      if (cap_period) tone_period <= rom_data;
    end
  end

  // Rotary note-length setting with saturation at both ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_len_steps <= LEN_DEF;
    end else if (rotary_event) begin
      if (rotary_left) begin
        if (note_len_steps > LEN_MIN) note_len_steps <= note_len_steps - LEN_W'(1);
      end else begin
        if (note_len_steps < LEN_MAX) note_len_steps <= note_len_steps + LEN_W'(1);
      end
    end
  end

endmodule
